// File: rtl/sdram_arbiter_if.sv
// Signal bundle between sdram_arbiter and its environment: requester ports plus the SDRAM controller side.
// slave is the arbiter's view; master is the requesters/controller view.
interface sdram_arbiter_if #(
   parameter int NUM_PORTS = 3
);
   logic [NUM_PORTS-1:0]       port_request;
   logic [NUM_PORTS-1:0]       port_ready;
   logic [NUM_PORTS-1:0][25:0] port_addr;
   logic [NUM_PORTS-1:0]       port_write;
   logic [NUM_PORTS-1:0]       port_burst;
   logic [NUM_PORTS-1:0][3:0]  port_wstrb;
   logic [NUM_PORTS-1:0][31:0] port_wdata;
   logic [NUM_PORTS-1:0]       port_rvalid;
   logic [31:0]                port_rdata;
   logic [25:0]                port_raddress;
   logic                       port_complete;

   logic                       mem_ready;
   logic                       mem_request;
   logic [25:0]                mem_addr;
   logic                       mem_write;
   logic                       mem_burst;
   logic [3:0]                 mem_wstrb;
   logic [31:0]                mem_wdata;
   logic                       mem_rvalid;
   logic [31:0]                mem_rdata;
   logic [25:0]                mem_raddress;
   logic                       mem_complete;
   logic                       err_unexpected;

   modport slave (
      input  port_request, port_addr, port_write, port_burst, port_wstrb, port_wdata,
      input  mem_ready, mem_rvalid, mem_rdata, mem_raddress, mem_complete,
      output port_ready, port_rvalid, port_rdata, port_raddress, port_complete,
      output mem_request, mem_addr, mem_write, mem_burst, mem_wstrb, mem_wdata,
      output err_unexpected
   );

   modport master (
      output port_request, port_addr, port_write, port_burst, port_wstrb, port_wdata,
      output mem_ready, mem_rvalid, mem_rdata, mem_raddress, mem_complete,
      input  port_ready, port_rvalid, port_rdata, port_raddress, port_complete,
      input  mem_request, mem_addr, mem_write, mem_burst, mem_wstrb, mem_wdata,
      input  err_unexpected
   );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter funnelling several requesters into one registered SDRAM command,
// with an owner FIFO that routes in-order read returns back to the issuing port.
module sdram_arbiter #(
   parameter int NUM_PORTS = 3,
   parameter int RQ_DEPTH  = 4
) (
   input logic            clock,
   input logic            reset,
   sdram_arbiter_if.slave bus
);
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int QW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PORT  = PW'(NUM_PORTS - 1);
   localparam logic [QW-1:0] LAST_SLOT  = QW'(RQ_DEPTH - 1);
   localparam logic [QW:0]   FULL_COUNT = (QW + 1)'(RQ_DEPTH);

   function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PW-1:0] idx);
      port_onehot = NUM_PORTS'(1'b1) << idx;
   endfunction

   function automatic logic [QW-1:0] next_ptr(input logic [QW-1:0] ptr);
      if (ptr == LAST_SLOT) begin
         next_ptr = '0;
      end else begin
         next_ptr = ptr + QW'(1'b1);
      end
   endfunction

   logic                 mem_request_r;
   logic [25:0]          mem_addr_r;
   logic                 mem_write_r;
   logic                 mem_burst_r;
   logic [3:0]           mem_wstrb_r;
   logic [31:0]          mem_wdata_r;
   logic [PW-1:0]        last_grant_r;
   logic [PW-1:0]        owner_r [RQ_DEPTH];
   logic [QW-1:0]        wr_ptr_r;
   logic [QW-1:0]        rd_ptr_r;
   logic [QW:0]          count_r;
   logic                 err_r;

   logic                 free_s;
   logic                 q_full_s;
   logic                 q_empty_s;
   logic [NUM_PORTS-1:0] eligible_s;
   logic                 grant_s;
   logic [PW-1:0]        grant_idx_s;
   logic                 fire_s;
   logic                 push_s;
   logic                 pop_s;

   assign free_s    = !mem_request_r || bus.mem_ready;
   assign q_full_s  = (count_r == FULL_COUNT);
   assign q_empty_s = (count_r == '0);
   // A same-cycle pop deliberately does not make a read eligible: fullness is judged on the registered count.
   assign eligible_s = bus.port_request & (bus.port_write | {NUM_PORTS{!q_full_s}});

   // Round-robin search starting one past the previous grant.
   always_comb begin : rr_select
      logic [PW-1:0] cand;
      cand        = '0;
      grant_s     = 1'b0;
      grant_idx_s = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = PW'((int'(last_grant_r) + k) % NUM_PORTS);
         if (!grant_s && eligible_s[cand]) begin
            grant_s     = 1'b1;
            grant_idx_s = cand;
         end else begin
            grant_s     = grant_s;
         end
      end
   end

   assign fire_s = free_s && grant_s && !reset;
   assign push_s = fire_s && !bus.port_write[grant_idx_s];
   assign pop_s  = bus.mem_rvalid && bus.mem_complete && !q_empty_s && !reset;

   // Command register: loads the granted port's command, drops to idle when freed with nothing eligible.
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_request_r <= 1'b0;
         last_grant_r  <= LAST_PORT;
      end else if (free_s) begin
         mem_request_r <= grant_s;
         if (grant_s) begin
            mem_addr_r   <= bus.port_addr[grant_idx_s];
            mem_write_r  <= bus.port_write[grant_idx_s];
            mem_burst_r  <= bus.port_burst[grant_idx_s];
            mem_wstrb_r  <= bus.port_wstrb[grant_idx_s];
            mem_wdata_r  <= bus.port_wdata[grant_idx_s];
            last_grant_r <= grant_idx_s;
         end
      end
   end

   // Owner FIFO storage: one entry per granted read.
   always_ff @(posedge clock) begin
      if (push_s) begin
         owner_r[wr_ptr_r] <= grant_idx_s;
      end
   end

   // Owner FIFO pointers and occupancy; reset discards anything still outstanding.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= next_ptr(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (QW + 1)'(1'b1);
            2'b01:   count_r <= count_r - (QW + 1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky flag for a read beat that has no owner to deliver to.
   always_ff @(posedge clock) begin
      if (reset) begin
         err_r <= 1'b0;
      end else if (bus.mem_rvalid && q_empty_s) begin
         err_r <= 1'b1;
      end
   end

   assign bus.port_ready     = fire_s ? port_onehot(grant_idx_s) : '0;
   assign bus.port_rvalid    = (bus.mem_rvalid && !q_empty_s && !reset) ? port_onehot(owner_r[rd_ptr_r]) : '0;
   assign bus.port_rdata     = bus.mem_rdata;
   assign bus.port_raddress  = bus.mem_raddress;
   assign bus.port_complete  = bus.mem_complete;
   assign bus.mem_request    = mem_request_r;
   assign bus.mem_addr       = mem_addr_r;
   assign bus.mem_write      = mem_write_r;
   assign bus.mem_burst      = mem_burst_r;
   assign bus.mem_wstrb      = mem_wstrb_r;
   assign bus.mem_wdata      = mem_wdata_r;
   assign bus.err_unexpected = err_r;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed requester/controller stimulus, expectations queued
// at issue time and checked by an independent negedge monitor.
module tb_sdram_arbiter;
   typedef struct packed {
      logic [25:0] addr;
      logic        write;
      logic        burst;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic [2:0]  rv;
      logic        complete;
      logic [31:0] rdata;
      logic [25:0] raddr;
   } rv_t;

   logic clock = 1'b0;
   logic reset;
   int   total;
   int   bad;

   sdram_arbiter_if #(.NUM_PORTS(3)) bus ();

   sdram_arbiter #(.NUM_PORTS(3), .RQ_DEPTH(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   cmd_t       pq0[$];
   cmd_t       pq1[$];
   cmd_t       pq2[$];
   logic [2:0] exp_grant_q[$];
   cmd_t       exp_cmd_q[$];
   rv_t        exp_rv_q[$];
   logic [2:0] ready_seen = 3'b000;
   cmd_t       mon_cmd;
   rv_t        mon_rv;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic cmd_t rd(input logic [25:0] a, input logic b);
      rd = '{addr: a, write: 1'b0, burst: b, wstrb: 4'h0, wdata: 32'h0};
   endfunction

   function automatic cmd_t wr(input logic [25:0] a, input logic [3:0] s, input logic [31:0] d);
      wr = '{addr: a, write: 1'b1, burst: 1'b0, wstrb: s, wdata: d};
   endfunction

   task automatic port_push(input int p, input cmd_t c);
      case (p)
         0:       pq0.push_back(c);
         1:       pq1.push_back(c);
         default: pq2.push_back(c);
      endcase
   endtask

   task automatic expect_grant(input logic [2:0] g, input cmd_t c);
      exp_grant_q.push_back(g);
      exp_cmd_q.push_back(c);
   endtask

   task automatic drive_port(input int p, input logic req, input cmd_t c);
      bus.port_request[p] = req;
      bus.port_addr[p]    = c.addr;
      bus.port_write[p]   = c.write;
      bus.port_burst[p]   = c.burst;
      bus.port_wstrb[p]   = c.wstrb;
      bus.port_wdata[p]   = c.wdata;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic beat(input logic [25:0] a, input logic [31:0] d, input logic c, input logic [2:0] rv);
      rv_t e;
      bus.mem_rvalid   = 1'b1;
      bus.mem_raddress = a;
      bus.mem_rdata    = d;
      bus.mem_complete = c;
      e = '{rv: rv, complete: c, rdata: d, raddr: a};
      exp_rv_q.push_back(e);
      tick();
      bus.mem_rvalid   = 1'b0;
      bus.mem_complete = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while ((exp_grant_q.size() != 0 || exp_cmd_q.size() != 0) && n < max) begin
         tick();
         n++;
      end
      chk("idle_within_budget", 64'(exp_grant_q.size() + exp_cmd_q.size()), 64'd0);
   endtask

   // Requester model: retire a port's head command after its ready pulse, then present the next one.
   always @(posedge clock) begin
      #2;
      if (ready_seen[0] && pq0.size() > 0) void'(pq0.pop_front());
      if (ready_seen[1] && pq1.size() > 0) void'(pq1.pop_front());
      if (ready_seen[2] && pq2.size() > 0) void'(pq2.pop_front());
      drive_port(0, pq0.size() > 0, (pq0.size() > 0) ? pq0[0] : '0);
      drive_port(1, pq1.size() > 0, (pq1.size() > 0) ? pq1[0] : '0);
      drive_port(2, pq2.size() > 0, (pq2.size() > 0) ? pq2[0] : '0);
   end

   // Monitor: compares grants, presented commands and read returns against the scoreboard.
   always @(negedge clock) begin
      ready_seen = bus.port_ready;
      if (!reset) begin
         if (bus.port_ready != 3'b000) begin
            if (exp_grant_q.size() == 0) chk("grant_unexpected", 64'(bus.port_ready), 64'd0);
            else chk("grant", 64'(bus.port_ready), 64'(exp_grant_q.pop_front()));
         end
         if (bus.mem_request) begin
            mon_cmd = {bus.mem_addr, bus.mem_write, bus.mem_burst, bus.mem_wstrb, bus.mem_wdata};
            if (exp_cmd_q.size() == 0) chk("cmd_unexpected", 64'(exp_cmd_q.size()), 64'd1);
            else if (bus.mem_ready) chk("cmd_accept", 64'(mon_cmd), 64'(exp_cmd_q.pop_front()));
            else chk("cmd_stall_hold", 64'(mon_cmd), 64'(exp_cmd_q[0]));
         end
         if (bus.mem_rvalid) begin
            mon_rv = '{rv: bus.port_rvalid, complete: bus.port_complete,
                       rdata: bus.port_rdata, raddr: bus.port_raddress};
            if (exp_rv_q.size() == 0) chk("beat_unexpected", 64'(exp_rv_q.size()), 64'd1);
            else chk("rvalid", 64'(mon_rv), 64'(exp_rv_q.pop_front()));
         end else if (bus.port_rvalid != 3'b000) begin
            chk("rvalid_idle", 64'(bus.port_rvalid), 64'd0);
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.port_request = '0;
      bus.port_addr    = '0;
      bus.port_write   = '0;
      bus.port_burst   = '0;
      bus.port_wstrb   = '0;
      bus.port_wdata   = '0;
      bus.mem_ready    = 1'b1;
      bus.mem_rvalid   = 1'b1;
      bus.mem_complete = 1'b1;
      bus.mem_rdata    = 32'h0;
      bus.mem_raddress = 26'h0;

      // All three ports ask for reads while reset is held; grants start at port 0 on release.
      port_push(0, rd(26'h0000010, 1'b0));
      port_push(0, rd(26'h0000014, 1'b0));
      port_push(1, rd(26'h0000020, 1'b0));
      port_push(2, rd(26'h0000030, 1'b0));
      expect_grant(3'b001, rd(26'h0000010, 1'b0));
      expect_grant(3'b010, rd(26'h0000020, 1'b0));
      expect_grant(3'b100, rd(26'h0000030, 1'b0));
      expect_grant(3'b001, rd(26'h0000014, 1'b0));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_ready", 64'(bus.port_ready), 64'd0);
         chk("reset_rvalid", 64'(bus.port_rvalid), 64'd0);
         chk("reset_mem_request", 64'(bus.mem_request), 64'd0);
         chk("reset_err", 64'(bus.err_unexpected), 64'd0);
      end
      reset            = 1'b0;
      bus.mem_rvalid   = 1'b0;
      bus.mem_complete = 1'b0;
      wait_idle(5);

      // Queue now full: port 1 write goes ahead, port 0 read waits for the first completion.
      port_push(0, rd(26'h0000040, 1'b0));
      port_push(1, wr(26'h0000050, 4'hC, 32'hA5A5_0050));
      expect_grant(3'b010, wr(26'h0000050, 4'hC, 32'hA5A5_0050));
      repeat (4) tick();
      beat(26'h0000010, 32'h1111_0010, 1'b1, 3'b001);
      expect_grant(3'b001, rd(26'h0000040, 1'b0));
      wait_idle(3);
      beat(26'h0000020, 32'h2222_0020, 1'b1, 3'b010);
      beat(26'h0000030, 32'h3333_0030, 1'b1, 3'b100);
      beat(26'h0000014, 32'h4444_0014, 1'b1, 3'b001);
      beat(26'h0000040, 32'h5555_0040, 1'b1, 3'b001);

      // Return order 1,0,2.
      port_push(1, rd(26'h0000300, 1'b0));
      expect_grant(3'b010, rd(26'h0000300, 1'b0));
      wait_idle(4);
      port_push(0, rd(26'h0000304, 1'b0));
      expect_grant(3'b001, rd(26'h0000304, 1'b0));
      wait_idle(4);
      port_push(2, rd(26'h0000308, 1'b0));
      expect_grant(3'b100, rd(26'h0000308, 1'b0));
      wait_idle(4);
      beat(26'h0000300, 32'h0000_0300, 1'b1, 3'b010);
      beat(26'h0000304, 32'h0000_0304, 1'b1, 3'b001);
      beat(26'h0000308, 32'h0000_0308, 1'b1, 3'b100);

      // Port 1 burst read, 16 beats.
      port_push(1, rd(26'h0001040, 1'b1));
      expect_grant(3'b010, rd(26'h0001040, 1'b1));
      wait_idle(4);
      for (int i = 0; i < 16; i++) begin
         beat(26'h0001040 + 26'(4 * i), 32'hB000_0000 + 32'(i), (i == 15), 3'b010);
      end

      // Queue drained: a stray beat is dropped and latches the error.
      beat(26'h0000000, 32'hBAD0_0001, 1'b1, 3'b000);
      chk("err_set", 64'(bus.err_unexpected), 64'd1);
      repeat (3) tick();
      chk("err_sticky", 64'(bus.err_unexpected), 64'd1);

      // Controller stalls with port 0's write in the register; port 2's write must wait.
      bus.mem_ready = 1'b0;
      port_push(0, wr(26'h0000200, 4'h3, 32'h1234_5678));
      expect_grant(3'b001, wr(26'h0000200, 4'h3, 32'h1234_5678));
      tick();
      port_push(2, wr(26'h0000100, 4'hF, 32'hDEAD_BEEF));
      repeat (5) tick();
      bus.mem_ready = 1'b1;
      expect_grant(3'b100, wr(26'h0000100, 4'hF, 32'hDEAD_BEEF));
      wait_idle(4);

      // Reset in the middle of a burst discards the owner; the tail beats are orphans.
      port_push(0, rd(26'h0002000, 1'b1));
      expect_grant(3'b001, rd(26'h0002000, 1'b1));
      wait_idle(4);
      for (int i = 0; i < 5; i++) begin
         beat(26'h0002000 + 26'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 3'b001);
      end
      reset = 1'b1;
      tick();
      chk("midreset_err_clear", 64'(bus.err_unexpected), 64'd0);
      tick();
      reset = 1'b0;
      for (int i = 5; i < 16; i++) begin
         beat(26'h0002000 + 26'(4 * i), 32'hC000_0000 + 32'(i), (i == 15), 3'b000);
      end
      chk("orphan_err", 64'(bus.err_unexpected), 64'd1);

      tick();
      chk("grants_left", 64'(exp_grant_q.size()), 64'd0);
      chk("cmds_left", 64'(exp_cmd_q.size()), 64'd0);
      chk("beats_left", 64'(exp_rv_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 3: number of requesters (0=icache, 1=dcache, 2=blitter).
REQ-002 Parameter RQ_DEPTH, default 4: depth of the outstanding-read owner queue (power of 2).
REQ-003 clock  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 port_ready  output  [NUM_PORTS-1:0]  one-cycle pulse: port's command accepted this cycle.
REQ-006 port_request  input  [NUM_PORTS-1:0]  port has a pending command.
REQ-007 port_addr  input  [NUM_PORTS-1:0][25:0]  byte address.
REQ-008 port_write  input  [NUM_PORTS-1:0]  1=write, 0=read.
REQ-009 port_burst  input  [NUM_PORTS-1:0]  1=16-beat burst read, 0=single.
REQ-010 port_wstrb  input  [NUM_PORTS-1:0][3:0]  write byte enables.
REQ-011 port_wdata  input  [NUM_PORTS-1:0][31:0]  write data.
REQ-012 port_rvalid  output  [NUM_PORTS-1:0]  read beat valid for that port.
REQ-013 port_rdata  output  32  read data, broadcast to all ports.
REQ-014 port_raddress  output  26  read beat address, broadcast.
REQ-015 port_complete  output  1  final beat of the read, broadcast; qualify with port_rvalid.
REQ-016 mem_ready  input  1  SDRAM controller accepts the presented command this cycle.
REQ-017 mem_request, mem_addr[25:0], mem_write, mem_burst, mem_wstrb[3:0], mem_wdata[31:0]  output  registered command to the SDRAM controller.
REQ-018 mem_rvalid, mem_rdata[31:0], mem_raddress[25:0], mem_complete  input  read return stream from the controller, in issue order.
REQ-019 err_unexpected  output  1  sticky: read beat arrived with no recorded owner.

Function
REQ-020 The output command register SHALL be free when mem_request=0 or mem_ready=1 in the current cycle.
REQ-021 When the register is free, the arbiter SHALL select one eligible port by round-robin, starting at (last_grant+1) mod NUM_PORTS.
REQ-022 A port SHALL be eligible when port_request=1, and additionally, for a read, when the owner queue is not full (a pop in the same cycle does not count as freeing space).
REQ-023 The selected port's port_ready SHALL be 1 in the selection cycle T, combinationally, with all other port_ready bits 0.
REQ-024 At T+1 the arbiter SHALL present mem_request=1 with that port's addr/write/burst/wstrb/wdata, and SHALL update last_grant to the granted index.
REQ-025 If the register is freed and no port is eligible, mem_request SHALL be 0 next cycle.
REQ-026 mem_* command outputs SHALL hold stable while mem_request=1 and mem_ready=0.
REQ-027 Each granted read (single or burst) SHALL push the port index into the owner queue at T; writes SHALL NOT push.
REQ-028 A mem_rvalid beat SHALL drive port_rvalid only for the queue-head port, in the same cycle (combinational); rdata/raddress/complete pass through.
REQ-029 The queue SHALL pop when mem_rvalid=1 and mem_complete=1; a single read returns one beat with complete=1.
REQ-030 A simultaneous push and pop SHALL leave the occupancy unchanged; pointers SHALL wrap modulo RQ_DEPTH.
REQ-031 A beat arriving with the queue empty SHALL be dropped (no port_rvalid) and SHALL set err_unexpected.
REQ-032 port_request=0 SHALL never be granted, and a port's command SHALL be sampled only in its ready cycle.

Reset
REQ-033 While reset=1: port_ready=0, port_rvalid=0, mem_request=0, queue empty, last_grant=NUM_PORTS-1, err_unexpected=0; the other mem_* values are don't-care.
REQ-034 Reset asserted mid-burst SHALL discard the queue; beats arriving after reset is released SHALL follow REQ-031.

Verification
REQ-035 Ports 0,1,2 all requesting reads after reset, mem_ready=1 -> grants 0,1,2,0 in consecutive cycles; mem_addr follows 1 cycle later.
REQ-036 Port 1 burst read at 0x0001040, 16 beats returned -> port_rvalid=3'b010 for all 16 beats, complete on beat 16, queue empty afterwards.
REQ-037 mem_ready held 0 for 5 cycles with port 2 write 0x0000100/wdata 0xDEADBEEF pending -> command stable for 5 cycles, port_ready[2] pulses once after mem_ready rises.
REQ-038 4 single reads outstanding (queue full), port 0 read plus port 1 write pending -> port 1 granted, port 0 held until the first complete beat.
REQ-039 Single-read return order 1,0,2 -> port_rvalid=010,001,100 on the respective beats.
REQ-040 mem_rvalid with the queue empty (and reset asserted mid-burst) -> no port_rvalid, err_unexpected=1 until reset.
